addsub_buff_seq: RTL
====================

// Module: addsub_buff_seq
// PURPOSE
//   Sequencer for the 6-stage add/sub alignment buffer in the DCT datapath. Accepts a
//   valid/ready sample stream, issues samples into the buffer via its enable/in_data
//   pins, and tracks in-flight samples with a valid-token pipe matched to buffer latency.
//   Captures aligned buffer output into a credit-protected FIFO, tags row/block
//   boundaries, and drains the pipe at the end of each 8x8 block.
// PARAMETERS
//   DW          32  sample width (matches buffer in_data/out_data)
//   LATENCY     6   buffer latency: enable/in_data at cycle t -> out_data valid at t+6
//   ROW_LEN     8   samples per row
//   BLOCK_ROWS  8   rows per block
//   FIFO_DEPTH  8   output FIFO entries (must be >= LATENCY+1)
// PORTS
//   clk          in   1   clock
//   rst          in   1   asynchronous, active-low reset
//   in_valid     in   1   upstream sample valid
//   in_ready     out  1   sequencer accepts sample this cycle
//   in_data      in   DW  upstream sample
//   buf_enable   out  1   to buffer enable
//   buf_in_data  out  DW  to buffer in_data
//   buf_out_data in   DW  from buffer out_data
//   out_valid    out  1   FIFO head valid
//   out_ready    in   1   downstream accepts head
//   out_data     out  DW  FIFO head sample
//   out_last     out  1   head is last sample of a row
//   busy         out  1   state != IDLE
//   block_done   out  1   1-cycle pulse when block fully drained
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, all counters/token pipe/FIFO cleared; in_ready=0,
//     buf_enable=0, buf_in_data=0, out_valid=0, out_last=0, busy=0, block_done=0.
//     The buffer itself has no reset; stale buffer contents are discarded because the
//     token pipe is cleared.
//   credit_ok = (inflight + fifo_occ) < FIFO_DEPTH, computed from registered counts; a pop
//     in the same cycle is not credited until the next cycle.
//   in_ready = (state==IDLE || state==RUN) && credit_ok. accept = in_valid && in_ready.
//   buf_enable = accept; buf_in_data = accept ? in_data : 0 (combinational to buffer regs).
//   Token pipe: LATENCY-deep shift reg of {valid,last}; stage0 <= {accept, accept &&
//     col_cnt==ROW_LEN-1}. When token[LATENCY-1].valid==1, buf_out_data is pushed into the
//     FIFO with its last bit. inflight = popcount of token valids (kept as a counter).
//   FIFO: first-word fall-through; out_valid = !empty; pop = out_valid && out_ready.
//     Simultaneous push+pop leaves occupancy unchanged. Push into full FIFO cannot
//     happen by construction (credit rule); assertion flags it.
//   Counters: col_cnt 0..ROW_LEN-1 increments per accept, wraps to 0; row_cnt
//     0..BLOCK_ROWS-1 increments on accept when col_cnt wraps.
//   FSM:
//     IDLE  -> RUN   on first accept (that sample counts as col 0, row 0)
//     RUN   -> DRAIN on accept with col_cnt==ROW_LEN-1 && row_cnt==BLOCK_ROWS-1
//     DRAIN -> IDLE  when inflight==0 && fifo empty; block_done=1 in that cycle
//     DRAIN holds in_ready=0; in_valid is ignored.
//   Throughput: 1 sample/clk while out_ready stays high; latency in_data -> out_valid
//     is LATENCY+1 cycles (FIFO write cycle included).
//   Backpressure: out_ready low stalls issue once inflight+occ reaches FIFO_DEPTH; no
//     sample is ever dropped or duplicated.
// TESTING
//   1 Reset, then 64 samples 0..63 with in_valid=1 and out_ready=1 -> out_data 0..63 in
//     order; first out_valid 7 cycles after first accept; out_last on 7,15,..,63;
//     block_done 1 cycle after 63 is popped; busy low afterwards.
//   2 out_ready=0 from start, stream in_valid=1 -> exactly 8 accepts, then in_ready=0;
//     raise out_ready -> stream resumes, all 64 samples in order, none dropped.
//   3 in_valid toggling 1/0 every cycle -> buf_enable mirrors accepts; buffer zeros
//     from idle cycles never reach the FIFO; output = input sequence.
//   4 After 64th accept, hold in_valid=1 -> in_ready=0 through DRAIN; next block
//     accepted only after block_done; col_cnt/row_cnt restart at 0.
//   5 Assert rst=0 mid-block (sample 20 in flight) -> all outputs 0 immediately;
//     after release a fresh 64-sample block outputs only new data.
//   6 Random out_ready at 30% duty over 4 blocks -> scoreboard match; the FIFO-overflow
//     assertion never fires.

Source files
------------

// File: rtl/addsub_buff_seq.sv
// addsub_buff_seq: feeds the 6-stage add/sub alignment buffer from a valid/ready stream,
// tracks in-flight samples with a token pipe, and collects aligned results in a credit-protected FIFO.
module addsub_buff_seq #(
  parameter int unsigned DW         = 32,
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned ROW_LEN    = 8,
  parameter int unsigned BLOCK_ROWS = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          buf_enable,
  output logic [DW-1:0] buf_in_data,
  input  logic [DW-1:0] buf_out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          block_done
);

  localparam int unsigned CLW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned RWW = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned IFW = $clog2(LATENCY + 1);
  localparam int unsigned OCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW  = $clog2(LATENCY + FIFO_DEPTH + 1);

  localparam logic [CLW-1:0] COL_LAST   = CLW'(ROW_LEN - 1);
  localparam logic [RWW-1:0] ROW_LAST   = RWW'(BLOCK_ROWS - 1);
  localparam logic [AW-1:0]  PTR_LAST   = AW'(FIFO_DEPTH - 1);
  localparam logic [OCW-1:0] OCC_FULL   = OCW'(FIFO_DEPTH);
  localparam logic [SW-1:0]  CREDIT_MAX = SW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               en_q;
  logic [CLW-1:0]     col_q, col_d;
  logic [RWW-1:0]     row_q, row_d;
  logic [LATENCY-1:0] tok_v_q, tok_v_d;
  logic [LATENCY-1:0] tok_l_q, tok_l_d;
  logic [IFW-1:0]     inflight_q, inflight_d;
  logic [OCW-1:0]     occ_q, occ_d;
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [DW-1:0]      mem      [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];

  logic credit_ok, accept, push, pop, empty, full, row_end, block_end, drained;

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OCC_FULL);
  assign credit_ok = (SW'(inflight_q) + SW'(occ_q)) < CREDIT_MAX;
  assign row_end   = (col_q == COL_LAST);
  assign block_end = row_end && (row_q == ROW_LAST);
  assign drained   = (inflight_q == '0) && empty;

  // en_q keeps in_ready low while reset is asserted and releases it one edge later
  assign in_ready    = en_q && credit_ok && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign accept      = in_valid && in_ready;
  assign buf_enable  = accept;
  assign buf_in_data = accept ? in_data : '0;
  assign busy        = (state_q != S_IDLE);

  assign push      = tok_v_q[LATENCY-1];
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_q] : '0;
  assign out_last  = out_valid && mem_last[rd_q];

  always_comb begin
    state_d    = state_q;
    block_done = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = block_end ? S_DRAIN : S_RUN;
      S_RUN:   if (accept && block_end) state_d = S_DRAIN;
      S_DRAIN: if (drained) begin
        block_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (row_end) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    tok_v_d    = {tok_v_q[LATENCY-2:0], accept};
    tok_l_d    = {tok_l_q[LATENCY-2:0], accept && row_end};
    inflight_d = inflight_q + IFW'(accept) - IFW'(push);
    occ_d      = occ_q + OCW'(push) - OCW'(pop);
    wr_d       = push ? ((wr_q == PTR_LAST) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d       = pop  ? ((rd_q == PTR_LAST) ? '0 : rd_q + 1'b1) : rd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      tok_v_q    <= '0;
      tok_l_q    <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= 1'b1;
      col_q      <= col_d;
      row_q      <= row_d;
      tok_v_q    <= tok_v_d;
      tok_l_q    <= tok_l_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // Storage needs no reset: pointers/occupancy gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q]      <= buf_out_data;
      mem_last[wr_q] <= tok_l_q[LATENCY-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule
